led_blink_arbiter: RTL
======================

Name: led_blink_arbiter

Overview:
- Shares one status LED between NUM_REQ requesters.
- Each requester asks for an N-blink burst; the block grants requesters round-robin and plays the burst with fixed on/off/gap timing.
- Timing is derived from an internal clock-enable prescaler, so the LED is driven in the clk domain with no derived clocks.
- Sits between software/status sources and the board LED pin, replacing ad-hoc free-running blinkers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLK_DIV, 50000000, clk cycles per timing tick.
- ON_TICKS, 2, ticks LED is high per blink.
- OFF_TICKS, 2, ticks LED is low between blinks.
- GAP_TICKS, 6, ticks LED is low after the last blink, before ack.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  request level per requester; held until its ack.
- count  in  4*NUM_REQ  blink count per requester, slice i = count[4i+3:4i].
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high while a burst is in progress.
- led  out  1  LED drive, active-high.

Behaviour:
- Reset (async, active-low):
  - led=0, busy=0, ack=0, grant_id=0.
  - State IDLE; round-robin pointer=0; prescaler loaded with CLK_DIV-1.
- Prescaler:
  - Down-counter; tick=1 for one cycle when it reaches 0, then reloads CLK_DIV-1.
  - Synchronously reloaded on every grant, so the first phase is exactly aligned.
- Phase counter: counts ticks within ON/OFF/GAP; cleared on every state change.
- State IDLE:
  - If any req[i]=1 (excluding the requester acked in this same cycle), grant the first set bit searching from pointer upward with wrap.
  - On grant: latch count slice into remaining; grant_id<=i; pointer<=i+1 mod NUM_REQ; busy<=1.
  - Next state: ON if remaining!=0 (led<=1), else GAP.
  - Grant decision to registered led=1 latency: 1 cycle.
- State ON:
  - led=1 for exactly ON_TICKS*CLK_DIV cycles.
  - Then led<=0, remaining<=remaining-1, go to OFF.
- State OFF:
  - Lasts OFF_TICKS*CLK_DIV cycles.
  - Then go to GAP if remaining==0, else go to ON with led<=1.
- State GAP:
  - led=0 for GAP_TICKS*CLK_DIV cycles.
  - Then go to IDLE with ack[grant_id]<=1 and busy<=0 in the same cycle; ack lasts 1 cycle.
  - The acked requester is masked from arbitration in its ack cycle. If it still holds req afterwards, that counts as a new request arbitrated in normal round-robin order.
- Count 0: granted and consumes the round-robin slot. LED stays low; ack follows after GAP only.
- req drop mid-burst: the burst completes and ack still pulses. No abort.
- count changing mid-burst: ignored; the value is latched at grant.
- Simultaneous requests: resolved strictly by round-robin. Each requester is served at most once per NUM_REQ grants while the others keep requesting.
- Burst length in cycles: 1 + count*(ON_TICKS+OFF_TICKS)*CLK_DIV + GAP_TICKS*CLK_DIV, from grant cycle to ack cycle inclusive of the ack cycle.
- Reset asserted mid-burst: all outputs go to reset values immediately, with no ack for the aborted burst.
- Width rules:
  - remaining is 4 bits and never underflows, because it only decrements in ON.
  - Phase counter width is $clog2(max(ON_TICKS, OFF_TICKS, GAP_TICKS)+1).

Decomposition:
- Shared package led_pkg holds:
  - State enum (IDLE, ON, OFF, GAP).
  - CNT_W=4 constant.
  - Function computing $clog2-based widths.
- One sub-module, led_tick_prescaler:
  - Inputs clk, reset, clr.
  - Output tick.
  - Parameter CLK_DIV.
  - Reusable by other LED/status blocks.

Test Plan:
All scenarios use CLK_DIV=4, ON_TICKS=2, OFF_TICKS=1, GAP_TICKS=3.
1. req[0]=1, count0=3 -> led high 8 cycles, low 4 cycles, three times, then low 12. ack[0] pulses once, 49 cycles after the grant cycle. busy is high throughout and falls with ack.
2. req=4'b1111, all counts=1 -> grants in order 0,1,2,3, each burst 25 cycles. Dropping each req on its ack leaves the arbiter IDLE with busy=0.
3. After serving requester 2, req[1] and req[3] both rise in the same cycle -> grant_id=3 first, then 1.
4. req[2]=1, count2=0 -> led never rises; ack[2] arrives 13 cycles after the grant.
5. reset pulled low 10 cycles into a burst -> led, busy and ack are 0 immediately. After release with req held, the burst restarts from a fresh grant with a full ON phase of 8 cycles.
6. req[0] dropped during the second blink of a count=3 burst -> remaining blinks and GAP complete, ack[0] pulses, and there is no regrant.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: shared FSM state type, blink count width and width helpers
// for the LED status blocks.
package led_pkg;

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} led_state_t;

    localparam int CNT_W = 4;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int width_of(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// led_tick_prescaler: one-cycle tick every CLK_DIV clk cycles; clr realigns
// the count so the next tick lands exactly CLK_DIV cycles later.
module led_tick_prescaler
    import led_pkg::*;
#(
    parameter int CLK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int W = width_of(CLK_DIV - 1);
    localparam logic [W-1:0] TOP = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= TOP;
        else
            cnt <= (clr || tick) ? TOP : cnt - 1'b1;
    end

endmodule

// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter: round-robin sharing of one status LED; each granted
// requester gets an N-blink burst followed by a quiet gap, then an ack.
module led_blink_arbiter
    import led_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int CLK_DIV   = 50000000,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 2,
    parameter int GAP_TICKS = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [CNT_W*NUM_REQ-1:0]   count,
    output logic [NUM_REQ-1:0]         ack,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       led
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int PH_W = width_of(max3(ON_TICKS, OFF_TICKS, GAP_TICKS));

    led_state_t       state, state_n;
    logic [ID_W-1:0]  ptr, ptr_n, pick, gid_n;
    logic [CNT_W-1:0] remaining, rem_n;
    logic [PH_W-1:0]  phase, phase_n, lim;
    logic [NUM_REQ-1:0] eligible, ack_n;
    logic             tick, grant, found, done, led_n, busy_n;
    int               idx;

    led_tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (grant),
        .tick  (tick)
    );

    // A requester acked this cycle must not be regranted in the same cycle.
    assign eligible = req & ~ack;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    assign lim  = (state == ON)  ? PH_W'(ON_TICKS - 1) :
                  (state == OFF) ? PH_W'(OFF_TICKS - 1) : PH_W'(GAP_TICKS - 1);
    assign done = tick && (phase == lim);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        rem_n   = remaining;
        gid_n   = grant_id;
        led_n   = led;
        busy_n  = busy;
        ack_n   = '0;
        grant   = 1'b0;
        phase_n = (tick && state != IDLE) ? phase + 1'b1 : phase;
        case (state)
            IDLE: if (found) begin
                grant   = 1'b1;
                gid_n   = pick;
                ptr_n   = (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
                rem_n   = count[int'(pick)*CNT_W +: CNT_W];
                busy_n  = 1'b1;
                led_n   = (rem_n != '0);
                state_n = (rem_n != '0) ? ON : GAP;
            end
            ON: if (done) begin
                led_n   = 1'b0;
                rem_n   = remaining - 1'b1;
                state_n = OFF;
            end
            OFF: if (done) begin
                led_n   = (remaining != '0);
                state_n = (remaining != '0) ? ON : GAP;
            end
            GAP: if (done) begin
                ack_n[grant_id] = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: ;
        endcase
        if (state_n != state)
            phase_n = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            phase     <= '0;
            grant_id  <= '0;
            led       <= 1'b0;
            busy      <= 1'b0;
            ack       <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            remaining <= rem_n;
            phase     <= phase_n;
            grant_id  <= gid_n;
            led       <= led_n;
            busy      <= busy_n;
            ack       <= ack_n;
        end
    end

endmodule
